// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pkg: colour-mode enum and timing-total helper for vga_window_streamer.
// Rev 1.0
// ----------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK    = 2'b00,
    MODE_DOMINANT = 2'b01,
    MODE_DIRECT   = 2'b10,
    MODE_TEST     = 2'b11
  } vga_mode_e;

  localparam int CNT_WIDTH = 12;

  function automatic int vga_total(input int active, input int front,
                                   input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_timing_gen: pixel-tick prescaler, h/v counters, raw syncs, frame pulses.
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 23,
  parameter int CLK_DIV  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 tick,
  output logic                 frame_start,
  output logic                 frame_pulse,
  output logic [CNT_WIDTH-1:0] h_cnt,
  output logic [CNT_WIDTH-1:0] v_cnt,
  output logic                 hsync_raw,
  output logic                 vsync_raw
);

  localparam int H_TOTAL   = vga_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL   = vga_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int PRE_WIDTH = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PRE_WIDTH-1:0] prescaler;

  assign tick        = (prescaler == PRE_WIDTH'(CLK_DIV - 1));
  assign frame_start = tick && (h_cnt == '0) && (v_cnt == '0);

  assign hsync_raw = (h_cnt >= CNT_WIDTH'(H_ACTIVE + H_FRONT)) &&
                     (h_cnt <  CNT_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC));
  assign vsync_raw = (v_cnt >= CNT_WIDTH'(V_ACTIVE + V_FRONT)) &&
                     (v_cnt <  CNT_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= frame_start;
      if (tick) begin
        prescaler <= '0;
        if (h_cnt == CNT_WIDTH'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == CNT_WIDTH'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_window_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_window_streamer: VGA raster with windowed pixel-read stream and colour
// mapping. Optional macro VGA_TEST_PATTERN_EN enables colour bars in mode 11.  Rev 1.0
// ----------------------------------------------------------------------------
module vga_window_streamer
  import vga_pkg::*;
#(
  parameter int   COLOR_WIDTH = 16,
  parameter int   OUT_WIDTH   = 4,
  parameter int   H_ACTIVE    = 800,
  parameter int   H_FRONT     = 40,
  parameter int   H_SYNC      = 128,
  parameter int   H_BACK      = 88,
  parameter int   V_ACTIVE    = 600,
  parameter int   V_FRONT     = 1,
  parameter int   V_SYNC      = 4,
  parameter int   V_BACK      = 23,
  parameter int   CLK_DIV     = 2,
  parameter logic HSYNC_POL   = 1'b1,
  parameter logic VSYNC_POL   = 1'b1,
  parameter int   WIN_W       = 128,
  parameter int   WIN_H       = 128,
  parameter int   ADDR_WIDTH  = $clog2(WIN_W * WIN_H)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [11:0]            win_x_i,
  input  logic [11:0]            win_y_i,
  input  logic [1:0]             mode_i,
  output logic                   rd_en_o,
  output logic [ADDR_WIDTH-1:0]  rd_addr_o,
  input  logic [COLOR_WIDTH-1:0] red_i,
  input  logic [COLOR_WIDTH-1:0] green_i,
  input  logic [COLOR_WIDTH-1:0] blue_i,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic [OUT_WIDTH-1:0]   red_o,
  output logic [OUT_WIDTH-1:0]   green_o,
  output logic [OUT_WIDTH-1:0]   blue_o,
  output logic                   frame_o
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [1:0]           rst_sync;
  logic                 rst_n;
  logic                 tick, frame_start, hsync_raw, vsync_raw;
  logic [CNT_WIDTH-1:0] h_cnt, v_cnt;

  // Assert asynchronously, release two clocks after rst_n_i rises.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk(clk_i), .rst_n(rst_n), .tick(tick), .frame_start(frame_start),
    .frame_pulse(frame_o), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync_raw(hsync_raw), .vsync_raw(vsync_raw)
  );

  logic [11:0] sx_q, sy_q, sx, sy;
  vga_mode_e   mode_q, mode_eff;

  // The frame's first pixel already uses the values being captured.
  assign sx       = frame_start ? win_x_i : sx_q;
  assign sy       = frame_start ? win_y_i : sy_q;
  assign mode_eff = frame_start ? vga_mode_e'(mode_i) : mode_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sx_q   <= '0;
      sy_q   <= '0;
      mode_q <= MODE_BLACK;
    end else if (frame_start) begin
      sx_q   <= win_x_i;
      sy_q   <= win_y_i;
      mode_q <= vga_mode_e'(mode_i);
    end
  end

  logic [12:0] h13, v13, x_lo, y_lo, dx, dy;
  logic        h_act, v_act, in_win, test_sel;
  logic [2:0]  bar;

  assign h13    = {1'b0, h_cnt};
  assign v13    = {1'b0, v_cnt};
  assign x_lo   = {1'b0, sx};
  assign y_lo   = {1'b0, sy};
  assign dx     = h13 - x_lo;
  assign dy     = v13 - y_lo;
  assign h_act  = h_cnt < CNT_WIDTH'(H_ACTIVE);
  assign v_act  = v_cnt < CNT_WIDTH'(V_ACTIVE);
  assign in_win = (h13 >= x_lo) && (h13 < x_lo + 13'(WIN_W)) &&
                  (v13 >= y_lo) && (v13 < y_lo + 13'(WIN_H)) && h_act && v_act;
  assign bar    = 3'(h_cnt / CNT_WIDTH'(BAR_W));

`ifdef VGA_TEST_PATTERN_EN
  assign test_sel = (mode_eff == MODE_TEST);
`else
  assign test_sel = 1'b0;
`endif

  logic      hs1, vs1, act1, test1;
  logic [2:0] bar1;
  vga_mode_e mode1;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      act1      <= 1'b0;
      test1     <= 1'b0;
      bar1      <= '0;
      mode1     <= MODE_BLACK;
    end else if (tick) begin
      rd_en_o   <= in_win && !test_sel;
      rd_addr_o <= in_win ? ADDR_WIDTH'(dy) * ADDR_WIDTH'(WIN_W) + ADDR_WIDTH'(dx) : '0;
      hs1       <= hsync_raw;
      vs1       <= vsync_raw;
      act1      <= h_act && v_act;
      test1     <= test_sel;
      bar1      <= bar;
      mode1     <= mode_eff;
    end
  end

  logic [OUT_WIDTH-1:0] r_nxt, g_nxt, b_nxt;

  // rd_en_o doubles as the stage-1 in-window flag for the memory-driven modes.
  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    if (test1) begin
      if (act1) begin
        r_nxt = {OUT_WIDTH{bar1[2]}};
        g_nxt = {OUT_WIDTH{bar1[1]}};
        b_nxt = {OUT_WIDTH{bar1[0]}};
      end
    end else if (rd_en_o) begin
      case (mode1)
        MODE_DOMINANT: begin
          if (red_i > green_i && red_i > blue_i)        r_nxt = '1;
          else if (green_i > red_i && green_i > blue_i) g_nxt = '1;
          else if (blue_i > red_i && blue_i > green_i)  b_nxt = '1;
        end
        MODE_DIRECT: begin
          r_nxt = red_i[COLOR_WIDTH-1 -: OUT_WIDTH];
          g_nxt = green_i[COLOR_WIDTH-1 -: OUT_WIDTH];
          b_nxt = blue_i[COLOR_WIDTH-1 -: OUT_WIDTH];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
      hsync_o <= ~HSYNC_POL;
      vsync_o <= ~VSYNC_POL;
    end else if (tick) begin
      red_o   <= r_nxt;
      green_o <= g_nxt;
      blue_o  <= b_nxt;
      hsync_o <= hs1 ? HSYNC_POL : ~HSYNC_POL;
      vsync_o <= vs1 ? VSYNC_POL : ~VSYNC_POL;
    end
  end

endmodule
`default_nettype wire

// File: doc/vga_window_streamer.md
Name: vga_window_streamer

Overview:
- Parametrised VGA raster generator with a runtime-positioned image window.
- Generates h/v timing from a clock-divided pixel tick and drives a read-address/enable stream to an external synchronous pixel memory (1-tick read latency).
- Maps returned RGB samples to the DAC outputs according to a selectable colour mode.
- Sits between the frame/image buffer and the board VGA connector.

Parameters:
- COLOR_WIDTH, 16: width of each input colour sample.
- OUT_WIDTH, 4: width of each DAC output channel.
- H_ACTIVE / H_FRONT / H_SYNC / H_BACK, 800 / 40 / 128 / 88: horizontal timing, in pixel ticks.
- V_ACTIVE / V_FRONT / V_SYNC / V_BACK, 600 / 1 / 4 / 23: vertical timing, in lines.
- CLK_DIV, 2: clk_i cycles per pixel tick; must be ≥1.
- HSYNC_POL / VSYNC_POL, 1 / 1: active level of each sync output.
- WIN_W / WIN_H, 128 / 128: window size in pixels.
- ADDR_WIDTH, $clog2(WIN_W*WIN_H): read address width.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous, active-low reset
- win_x_i  in  12  window left column
- win_y_i  in  12  window top line
- mode_i  in  2  colour mode: 00 black, 01 dominant, 10 direct, 11 test (optional)
- rd_en_o  out  1  pixel read request
- rd_addr_o  out  ADDR_WIDTH  window-linear read address
- red_i / green_i / blue_i  in  COLOR_WIDTH each  pixel data, valid one tick after rd_en_o
- hsync_o / vsync_o  out  1 each  sync outputs
- red_o / green_o / blue_o  out  OUT_WIDTH each  DAC outputs
- frame_o  out  1  one-clk pulse at the start of each frame

Behaviour:
- Reset (async assert, sync deassert internally):
  - prescaler, h_cnt, v_cnt = 0
  - rd_en_o = 0, rd_addr_o = 0, colour outputs = 0, frame_o = 0
  - hsync_o = ~HSYNC_POL, vsync_o = ~VSYNC_POL
  - Reset mid-frame restarts at h = v = 0 on release.
- Pixel tick:
  - prescaler counts 0..CLK_DIV-1; tick = (prescaler == CLK_DIV-1). CLK_DIV = 1 gives a tick every clk.
  - All pipeline registers advance only on tick.
- Counters:
  - h_cnt wraps at H_TOTAL-1 and then increments v_cnt.
  - v_cnt wraps at V_TOTAL-1 (800x600 defaults: 1056 x 628).
- Shadow registers:
  - On the tick where h_cnt = v_cnt = 0, win_x_i, win_y_i and mode_i are captured into shadow registers and frame_o pulses for one clk.
  - Input changes mid-frame take effect only at the next frame.
- Stage 1 (tick n):
  - in_win = (sx ≤ h < sx+WIN_W) and (sy ≤ v < sy+WIN_H) and h < H_ACTIVE and v < V_ACTIVE, computed at 13 bits with no overflow. Window portions beyond the active area are clipped.
  - rd_en_o = in_win.
  - rd_addr_o = (v-sy)*WIN_W + (h-sx) when in_win, else 0.
  - Raw syncs are computed: hsync active for H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC; vsync likewise on v.
- Stage 2 (tick n+1):
  - Colour outputs are registered.
  - Syncs are delayed one stage so outputs stay pixel-aligned. Total latency from counter to pins: 2 ticks.
- Colour modes:
  - 00: all channels 0.
  - 01 (dominant): the strictly largest channel outputs all-ones, the others 0; any tie for maximum gives black.
  - 10 (direct): each channel outputs its top OUT_WIDTH bits of input.
  - Outside the window or in blanking: 0 in every mode except 11.

Optional Feature:
- VGA_TEST_PATTERN_EN defined: mode 11 outputs 8 full-screen vertical colour bars.
  - bar = h / (H_ACTIVE/8); bits {r,g,b} = bar[2:0], each bit expanded to all-ones.
  - Bars are shown in the active area only, ignore the window, and hold rd_en_o = 0.
  - Latency is the same as the other modes.
- Undefined: mode 11 behaves as 00.

Decomposition:
- Package vga_pkg: mode enum vga_mode_e (MODE_BLACK, MODE_DOMINANT, MODE_DIRECT, MODE_TEST) and the H_TOTAL/V_TOTAL derivation function.
- Sub-module vga_timing_gen: prescaler, counters, raw syncs, tick and frame pulses.

Test Plan:
- Reset, then CLK_DIV=2 -> tick every 2nd clk. hsync_o active (1) for exactly 128 ticks, starting 842 ticks after h=0 (840 + 2-stage latency). Line period 1056 ticks; vsync active for lines 601..604 (plus latency).
- win=(336,236), mode 10 -> first rd_en_o at h=336,v=236 with addr 0; addr 127 at h=463; addr 128 at h=336,v=237; addr never exceeds 16383.
- Mode 01 with inputs R=0x8000, G=0x7FFF, B=0 -> red_o=0xF, others 0. Inputs R=G=0x8000 -> all outputs 0.
- win_x_i changed 300->400 mid-frame -> window position is unchanged until after the next frame_o pulse.
- win=(750,580) -> rd_en_o only for h 750..799 and v 580..599, never in blanking.
- rst_n_i asserted mid-line -> outputs immediately 0 and syncs inactive; after release, frame_o fires on the first tick.
